// File: rtl/fft_bitrev_reorder.sv
// Reorders the bit-reversed FFT output stream into natural order.
// A two-bank ping-pong RAM is written linearly and read at bit-reversed addresses.
module fft_bitrev_reorder #(
   parameter  int N      = 64,
   parameter  int WIDTH  = 8,
   parameter  int BITREV = 1,
   localparam int LOGN   = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable_in,
   input  logic [WIDTH-1:0] in_re,
   input  logic [WIDTH-1:0] in_im,
   output logic             enable_out,
   output logic [WIDTH-1:0] out_re,
   output logic [WIDTH-1:0] out_im,
   output logic [LOGN-1:0]  out_index,
   output logic             frame_start
);

   typedef enum logic {S_IDLE, S_READ} state_t;

   logic [2*WIDTH-1:0] r_mem [0:2*N-1];
   logic [2*WIDTH-1:0] r_q_data;
   logic [LOGN-1:0]    r_wr_cnt;
   logic [LOGN-1:0]    r_rd_cnt;
   logic [LOGN-1:0]    r_q_idx;
   logic [LOGN-1:0]    w_rd_cnt_nxt;
   logic [LOGN-1:0]    w_rd_addr;
   logic               r_wr_bank;
   logic               r_rd_bank;
   logic               w_rd_bank_nxt;
   logic               r_q_valid;
   logic               w_frame_done;
   logic               w_rd_en;
   state_t             r_state;
   state_t             w_state_nxt;

   assign w_frame_done = enable_in && (r_wr_cnt == LOGN'(N - 1));
   assign w_rd_en      = (r_state == S_READ);

   generate
      if (BITREV != 0) begin : g_bitrev
         for (genvar gi = 0; gi < LOGN; gi++) begin : g_bit
            assign w_rd_addr[gi] = r_rd_cnt[LOGN-1-gi];
         end
      end else begin : g_linear
         assign w_rd_addr = r_rd_cnt;
      end
   endgenerate

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_cnt  <= '0;
         r_wr_bank <= 1'b0;
      end else if (enable_in) begin
         r_wr_cnt <= r_wr_cnt + 1'b1;
         if (w_frame_done) r_wr_bank <= ~r_wr_bank;
      end
   end

   // NOTE: the RAM and its read register are deliberately not reset; a reset
   // clears the valid pipeline instead, so stale contents can never reach the outputs.
   always_ff @(posedge clk) begin
      if (enable_in) r_mem[{r_wr_bank, r_wr_cnt}] <= {in_re, in_im};
      if (w_rd_en)   r_q_data <= r_mem[{r_rd_bank, w_rd_addr}];
   end

   // NOTE: defaults first so every path assigns every signal and no latch is inferred.
   always_comb begin
      w_state_nxt   = r_state;
      w_rd_cnt_nxt  = r_rd_cnt;
      w_rd_bank_nxt = r_rd_bank;
      if (w_frame_done) begin
         // Covers both launch from idle and the seamless hand-over to the other bank.
         w_state_nxt   = S_READ;
         w_rd_cnt_nxt  = '0;
         w_rd_bank_nxt = r_wr_bank;
      end else if (r_state == S_READ) begin
         w_rd_cnt_nxt = r_rd_cnt + 1'b1;
         if (r_rd_cnt == LOGN'(N - 1)) w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_rd_cnt  <= '0;
         r_rd_bank <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_cnt  <= w_rd_cnt_nxt;
         r_rd_bank <= w_rd_bank_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q_valid <= 1'b0;
         r_q_idx   <= '0;
      end else begin
         r_q_valid <= w_rd_en;
         r_q_idx   <= r_rd_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_out  <= 1'b0;
         frame_start <= 1'b0;
         out_re      <= '0;
         out_im      <= '0;
         out_index   <= '0;
      end else begin
         enable_out  <= r_q_valid;
         frame_start <= r_q_valid && (r_q_idx == '0);
         if (r_q_valid) begin
            out_re    <= r_q_data[2*WIDTH-1:WIDTH];
            out_im    <= r_q_data[WIDTH-1:0];
            out_index <= r_q_idx;
         end
      end
   end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench: a frame model pushes expected natural-order samples, stamped
// with their due cycle, and per-DUT monitors pop and compare them.
module tb_fft_bitrev_reorder;

   typedef struct {
      int         cyc;
      logic [7:0] re;
      logic [7:0] im;
      int         idx;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0, en4 = 1'b0;
   logic [7:0] re = '0, im = '0, re4 = '0, im4 = '0;

   logic       eo, fs, eo_l, fs_l, eo_b, fs_b;
   logic [7:0] ore, oim, ore_l, oim_l, ore_b, oim_b;
   logic [5:0] oidx;
   logic [1:0] oidx_l, oidx_b;

   exp_t       q[$], q_l[$], q_b[$];
   exp_t       e_m, e_l, e_b;
   logic [7:0] mb_re [64], mb_im [64];
   logic [7:0] sb_re [4];
   int         m_cnt = 0, s_cnt = 0;
   int         cyc = 0, n_out = 0;
   int         n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fft_bitrev_reorder #(.N(64), .WIDTH(8), .BITREV(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable_in(en), .in_re(re), .in_im(im),
      .enable_out(eo), .out_re(ore), .out_im(oim), .out_index(oidx), .frame_start(fs));

   fft_bitrev_reorder #(.N(4), .WIDTH(8), .BITREV(0)) u_lin4 (
      .clk(clk), .rst_n(rst_n), .enable_in(en4), .in_re(re4), .in_im(im4),
      .enable_out(eo_l), .out_re(ore_l), .out_im(oim_l), .out_index(oidx_l), .frame_start(fs_l));

   fft_bitrev_reorder #(.N(4), .WIDTH(8), .BITREV(1)) u_br4 (
      .clk(clk), .rst_n(rst_n), .enable_in(en4), .in_re(re4), .in_im(im4),
      .enable_out(eo_b), .out_re(ore_b), .out_im(oim_b), .out_index(oidx_b), .frame_start(fs_b));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [5:0] bitrev6(input logic [5:0] v);
      logic [5:0] r;
      for (int b = 0; b < 6; b++) r[b] = v[5-b];
      return r;
   endfunction

   function automatic logic [1:0] bitrev2(input logic [1:0] v);
      return {v[0], v[1]};
   endfunction

   // Drives one cycle on the N=64 DUT; a completed frame pushes its natural-order image.
   task automatic send(input logic v, input logic [7:0] r, input logic [7:0] i);
      @(posedge clk); #1;
      en = v; re = r; im = i;
      if (v) begin
         mb_re[m_cnt] = r;
         mb_im[m_cnt] = i;
         if (m_cnt == 63) begin
            for (int j = 0; j < 64; j++)
               q.push_back('{cyc + 3 + j, mb_re[bitrev6(6'(j))], mb_im[bitrev6(6'(j))], j});
            m_cnt = 0;
         end else m_cnt++;
      end
   endtask

   task automatic send4(input logic v, input logic [7:0] r);
      @(posedge clk); #1;
      en4 = v; re4 = r; im4 = ~r;
      if (v) begin
         sb_re[s_cnt] = r;
         if (s_cnt == 3) begin
            for (int j = 0; j < 4; j++) begin
               q_l.push_back('{cyc + 3 + j, sb_re[j], ~sb_re[j], j});
               q_b.push_back('{cyc + 3 + j, sb_re[bitrev2(2'(j))], ~sb_re[bitrev2(2'(j))], j});
            end
            s_cnt = 0;
         end else s_cnt++;
      end
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; en = 1'b0; en4 = 1'b0;
      q.delete(); q_l.delete(); q_b.delete();
      m_cnt = 0; s_cnt = 0;
      #1;
      check("rst_enable_out", 32'(eo), 0);
      check("rst_out_re", 32'(ore), 0);
      check("rst_out_im", 32'(oim), 0);
      check("rst_out_index", 32'(oidx), 0);
      check("rst_frame_start", 32'(fs), 0);
      check("rst_small_en", 32'({eo_l, eo_b}), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic drain();
      for (int k = 0; k < 400 && (q.size() + q_l.size() + q_b.size()) > 0; k++) @(posedge clk);
      check("drain_pending", 32'(q.size() + q_l.size() + q_b.size()), 0);
      repeat (4) @(posedge clk);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (eo) begin
            if (q.size() == 0) check("spurious_out", 32'(eo), 0);
            else begin
               e_m = q.pop_front();
               check("out_cycle", 32'(cyc), 32'(e_m.cyc));
               check("out_re", 32'(ore), 32'(e_m.re));
               check("out_im", 32'(oim), 32'(e_m.im));
               check("out_index", 32'(oidx), 32'(e_m.idx));
               check("frame_start", 32'(fs), 32'(e_m.idx == 0));
               n_out++;
            end
         end else check("frame_start_idle", 32'(fs), 0);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (eo_l) begin
            if (q_l.size() == 0) check("lin4_spurious", 32'(eo_l), 0);
            else begin
               e_l = q_l.pop_front();
               check("lin4_cycle", 32'(cyc), 32'(e_l.cyc));
               check("lin4_re", 32'(ore_l), 32'(e_l.re));
               check("lin4_im", 32'(oim_l), 32'(e_l.im));
               check("lin4_index", 32'(oidx_l), 32'(e_l.idx));
               check("lin4_fs", 32'(fs_l), 32'(e_l.idx == 0));
            end
         end
         if (eo_b) begin
            if (q_b.size() == 0) check("br4_spurious", 32'(eo_b), 0);
            else begin
               e_b = q_b.pop_front();
               check("br4_cycle", 32'(cyc), 32'(e_b.cyc));
               check("br4_re", 32'(ore_b), 32'(e_b.re));
               check("br4_im", 32'(oim_b), 32'(e_b.im));
               check("br4_index", 32'(oidx_b), 32'(e_b.idx));
               check("br4_fs", 32'(fs_b), 32'(e_b.idx == 0));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int target;
      logic [7:0] v;
      apply_reset();

      // Single frame: natural bin j carries re=j, im=-j.
      for (int i = 0; i < 64; i++) begin
         v = 8'(bitrev6(6'(i)));
         send(1'b1, v, -v);
      end
      send(1'b0, '0, '0);
      drain();

      // Three frames back to back, no idle cycle between them.
      for (int f = 0; f < 3; f++)
         for (int i = 0; i < 64; i++) begin
            v = 8'(bitrev6(6'(i))) + 8'(f * 64);
            send(1'b1, v, -v);
         end
      send(1'b0, '0, '0);
      drain();

      // Gapped input, one sample every other cycle.
      for (int i = 0; i < 64; i++) begin
         v = 8'(bitrev6(6'(i))) ^ 8'h5A;
         send(1'b1, v, 8'(i));
         send(1'b0, '0, '0);
      end
      drain();

      // Reset during readout, then during a partial write, then a clean frame.
      for (int i = 0; i < 64; i++) begin
         v = 8'(bitrev6(6'(i)));
         send(1'b1, v, -v);
      end
      send(1'b0, '0, '0);
      target = n_out + 20;
      for (int k = 0; k < 300 && n_out < target; k++) @(posedge clk);
      check("reached_sample20", 32'(n_out >= target), 1);
      apply_reset();
      for (int i = 0; i < 30; i++) send(1'b1, 8'(i + 100), 8'(i));
      apply_reset();
      for (int i = 0; i < 64; i++) begin
         v = 8'(bitrev6(6'(i))) + 8'd7;
         send(1'b1, v, ~v);
      end
      send(1'b0, '0, '0);
      drain();

      // Small N: linear readout versus bit-reversed readout of 5,6,7,8.
      for (int i = 0; i < 4; i++) send4(1'b1, 8'(5 + i));
      send4(1'b0, '0);
      drain();

      check("final_queue_main", 32'(q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Consumes the bit-reversed-order output stream of the FFT pipeline, i.e. the sdf4 chain's `enable_out`/`out_re`/`out_im`, and emits the same frame in natural order.
- Ping-pong buffer of two N-entry banks. Frames are written in arrival order and read back at bit-reversed addresses.
- Sits directly after the last FFT stage and is the reader for the frames that stage writes.

Parameters:
- N, 64, FFT frame length; power of 2, ≥4. LOGN = clog2(N).
- WIDTH, 8, bit width of each of re/im; data is signed two's complement and passes through unmodified.
- BITREV, 1, 1 = read at bit-reversed address; 0 = read at linear address (bypass/debug).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable_in  in  1  input sample valid, one sample per high cycle.
- in_re  in  WIDTH  input real part, bit-reversed order.
- in_im  in  WIDTH  input imaginary part.
- enable_out  out  1  output sample valid.
- out_re  out  WIDTH  output real part, natural order.
- out_im  out  WIDTH  output imaginary part.
- out_index  out  LOGN  natural-order bin index of the current output sample.
- frame_start  out  1  one-cycle pulse coincident with out_index==0 and enable_out=1.

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - wr_cnt=0, wr_bank=0, rd_active=0, rd_cnt=0;
  - enable_out=0, out_re=0, out_im=0, out_index=0, frame_start=0.
  - RAM contents are not reset. A partially written frame is discarded and a read in progress is aborted. Outputs stay 0 until the next completed frame.
- Writer:
  - On each clk edge with enable_in=1: mem[wr_bank][wr_cnt] <= {in_re,in_im}; wr_cnt <= wr_cnt+1, wrapping at N.
  - enable_in=0 holds wr_cnt, so gaps inside a frame are allowed and the frame resumes where it stopped.
  - On the edge that writes wr_cnt==N-1 (frame done): wr_bank toggles and a read is launched on the just-filled bank.
- Reader states:
  - IDLE → READ on frame done. Next edge: rd_cnt=0 and the read address is presented to the RAM.
  - Read address = bitrev(rd_cnt) over LOGN bits when BITREV=1; rd_cnt when BITREV=0.
  - Synchronous RAM read, then the output is driven from the RAM data. If frame done occurs on edge E, natural sample j appears on out_re/out_im with enable_out=1 after edge E+2+j, for j=0..N-1.
  - out_index=j and frame_start=1 only for j=0.
  - READ → IDLE after rd_cnt==N-1 is issued, unless a new frame done occurs on that same edge. In that case rd_cnt wraps to 0 on the other bank with no bubble, so back-to-back frames give a continuous enable_out.
  - Reads are always contiguous (N cycles) regardless of enable_in gaps.
- Hazards:
  - Input rate ≤1 sample/clk and a read takes exactly N cycles, so the bank being read is never written.
  - Writer and reader never address the same bank at the same time; no stall or backpressure exists.
- Outputs are registered. When enable_out=0, out_re/out_im/out_index hold their last value.
- Latency: 2 clk from the edge accepting the last input sample of a frame to the first output sample.

Test Plan:
- Bit-reversed output, N=64, BITREV=1:
  - Stimulus: one frame, sample i has in_re=bitrev6(i) and in_im=-bitrev6(i).
  - Response: out_re=j and out_im=-j for j=0..63 in order; enable_out high for exactly 64 cycles starting 2 clk after the last input; frame_start only at j=0.
- Back-to-back frames:
  - Stimulus: three frames with enable_in continuously high for 192 cycles, frame f carrying in_re=bitrev6(i)+f*64 (mod 256).
  - Response: enable_out continuously high for 192 cycles with no bubble; out_re sequence is 0..191 mod 256.
- Gapped input:
  - Stimulus: enable_in toggles 1,0,1,0 across one frame (128 cycles).
  - Response: output is still 64 contiguous cycles, natural order correct, starting 2 clk after the 64th accepted sample.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 at output sample 20 of frame 0, and again mid-write (sample 30) of the following frame.
  - Response: after each reset, enable_out=0 and outputs are 0 immediately; the next full frame after deassertion is reordered correctly and partial data never appears.
- Bypass and small N:
  - Stimulus: N=4 with BITREV=0 and input 5,6,7,8, then N=4 with BITREV=1 and the same input.
  - Response: BITREV=0 gives 5,6,7,8; BITREV=1 gives 5,7,6,8.
